// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: encodings, FSM
// states, trap causes and the ALU operation set.
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, ERR} state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } trap_cause_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  // Arithmetic wraps modulo 2^32; SLT is a signed compare yielding 0/1.
  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, a debug read port,
// one synchronous write port and an asynchronous clear. r0 is hardwired 0.
module mips_regfile (
  input  logic        clock,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] regs [32];

  // Register array with clear-on-reset and r0 write suppression.
  // NOTE: the array is reset because software relies on every register
  // reading zero after reset; a plain RAM macro cannot be used as a result.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == 5'd0) ? '0 : regs[raddr1];
  assign rdata2   = (raddr2   == 5'd0) ? '0 : regs[raddr2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/mc_mips_core.sv
// Multi-cycle MIPS-subset core with a single shared instruction/data memory
// port. FETCH/DECODE/EXEC/MEM/WB state machine, sticky trap on illegal
// instructions, misaligned addresses and (optionally) bus timeouts.
module mc_mips_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic              clock,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              instr_done,
  output logic              trap,
  output logic [1:0]        trap_cause,
  input  logic [4:0]        dbg_addr,
  output logic [31:0]       dbg_data
);

  state_e      state;
  trap_cause_e cause;
  logic [31:0] ir, a_reg, b_reg, alu_out, mdr;
  logic [31:0] wait_cnt;

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext;
  logic [25:0] jidx;
  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign jidx    = ir[25:0];
  assign imm_ext = sext16(ir[15:0]);

  logic is_jr;
  assign is_jr = (opcode == OP_RTYPE) && (funct == FN_JR);

  // Register file
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, rs_data, rt_data;

  // jal links in DECODE; everything else writes back in WB.
  assign rf_we    = (state == WB) || (state == DECODE && opcode == OP_JAL);
  assign rf_waddr = (state == DECODE) ? 5'd31 : ((opcode == OP_RTYPE) ? rd : rt);
  assign rf_wdata = (state == DECODE) ? pc : ((opcode == OP_LW) ? mdr : alu_out);

  mips_regfile u_regfile (
    .clock    (clock),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr1   (rs),
    .rdata1   (rs_data),
    .raddr2   (rt),
    .rdata2   (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Legality check of the opcode/funct pair.
  logic legal;
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first so no path leaves it unassigned and a latch is never inferred.
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: legal = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR};
      OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  // ALU operand/operation selection; lw/sw reuse ALU_ADD with the immediate.
  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_result;
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = imm_ext;
    if (opcode == OP_RTYPE) begin
      alu_b = b_reg;
      case (funct)
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end else if (opcode == OP_SLTI) begin
      alu_op = ALU_SLT;
    end
  end
  assign alu_result = alu(alu_op, a_reg, alu_b);

  // Memory port: a request is outstanding in FETCH and MEM only, and is
  // forced low while reset is held so a pending access drops immediately.
  logic [31:0] addr_full;
  assign addr_full = (state == MEM) ? alu_out : pc;
  assign mem_req   = (state == FETCH || state == MEM) && !rst;
  assign mem_we    = (state == MEM) && (opcode == OP_SW);
  assign mem_addr  = addr_full[ADDR_W-1:0];
  assign mem_wdata = b_reg;

  logic wait_expired;
  assign wait_expired = (MAX_WAIT != 0) && mem_req && !mem_ready &&
                        (wait_cnt == 32'(MAX_WAIT - 1));

  assign trap       = (state == ERR);
  assign trap_cause = cause;

  // Retirement pulse: asserted in the last cycle before returning to FETCH.
  always_comb begin
    instr_done = 1'b0;
    case (state)
      DECODE:  instr_done = (opcode == OP_J) || (opcode == OP_JAL) ||
                            (is_jr && rs_data[1:0] == 2'b00);
      EXEC:    instr_done = (opcode == OP_BEQ);
      MEM:     instr_done = mem_ready && (opcode == OP_SW);
      WB:      instr_done = 1'b1;
      default: instr_done = 1'b0;
    endcase
  end

  // Control FSM and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      cause    <= CAUSE_NONE;
      pc       <= RESET_PC;
      ir       <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir       <= mem_rdata;
            pc       <= pc + 32'd4;
            wait_cnt <= '0;
            state    <= DECODE;
          end else if (wait_expired) begin
            cause    <= CAUSE_TIMEOUT;
            wait_cnt <= '0;
            state    <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        DECODE: begin
          a_reg   <= rs_data;
          b_reg   <= rt_data;
          alu_out <= pc + (imm_ext << 2);
          if (!legal) begin
            cause <= CAUSE_ILLEGAL;
            state <= ERR;
          end else if (opcode == OP_J || opcode == OP_JAL) begin
            pc    <= {pc[31:28], jidx, 2'b00};
            state <= FETCH;
          end else if (is_jr) begin
            if (rs_data[1:0] != 2'b00) begin
              cause <= CAUSE_MISALIGN;
              state <= ERR;
            end else begin
              pc    <= rs_data;
              state <= FETCH;
            end
          end else begin
            state <= EXEC;
          end
        end

        EXEC: begin
          case (opcode)
            OP_BEQ: begin
              if (a_reg == b_reg) pc <= alu_out;
              state <= FETCH;
            end
            OP_LW, OP_SW: begin
              alu_out <= alu_result;
              if (alu_result[1:0] != 2'b00) begin
                cause <= CAUSE_MISALIGN;
                state <= ERR;
              end else begin
                state <= MEM;
              end
            end
            default: begin
              alu_out <= alu_result;
              state   <= WB;
            end
          endcase
        end

        MEM: begin
          if (mem_ready) begin
            if (opcode == OP_LW) mdr <= mem_rdata;
            wait_cnt <= '0;
            state    <= (opcode == OP_LW) ? WB : FETCH;
          end else if (wait_expired) begin
            cause    <= CAUSE_TIMEOUT;
            wait_cnt <= '0;
            state    <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        WB:      state <= FETCH;
        ERR:     state <= ERR;
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_mips_core.sv
// Directed self-checking bench for mc_mips_core: unified memory model with a
// programmable slow address, plus a second instance with MAX_WAIT=4 and a
// memory that never answers.
module tb_mc_mips_core;

  logic        clock = 1'b0;
  logic        rst, rst_t;
  logic        mem_req, mem_we, mem_ready, instr_done, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, dbg_data;
  logic [1:0]  trap_cause;
  logic [4:0]  dbg_addr;

  logic        t_req, t_we, t_done, t_trap;
  logic [31:0] t_addr, t_wdata, t_pc, t_dbg;
  logic [1:0]  t_cause;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clock = ~clock;

  mc_mips_core #(.RESET_PC(32'h0), .ADDR_W(32), .MAX_WAIT(0)) dut (
    .clock (clock), .rst (rst),
    .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata), .mem_ready (mem_ready),
    .pc (pc), .instr_done (instr_done), .trap (trap), .trap_cause (trap_cause),
    .dbg_addr (dbg_addr), .dbg_data (dbg_data)
  );

  mc_mips_core #(.RESET_PC(32'h0), .ADDR_W(32), .MAX_WAIT(4)) dut_to (
    .clock (clock), .rst (rst_t),
    .mem_req (t_req), .mem_we (t_we), .mem_addr (t_addr),
    .mem_wdata (t_wdata), .mem_rdata (32'h0), .mem_ready (1'b0),
    .pc (t_pc), .instr_done (t_done), .trap (t_trap), .trap_cause (t_cause),
    .dbg_addr (5'd0), .dbg_data (t_dbg)
  );

  // Memory model: 256 words, zero-wait except at slow_addr.
  logic [31:0] mem [256];
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_data;
  logic [31:0] slow_addr;
  int          slow_waits;
  int          wcnt;

  assign mem_ready = mem_req && (mem_addr != slow_addr || wcnt == slow_waits);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clock) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    else if (mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    if (rst || !mem_req || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clock);
    #1;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    ld_en = 1'b1; ld_idx = addr[9:2]; ld_data = data;
    @(posedge clock);
    #1;
    ld_en = 1'b0;
  endtask

  // Counts cycles from the current one until instr_done; -1 on timeout.
  task automatic wait_done(input int max_cycles, output int n);
    bit seen = 1'b0;
    n = -1;
    for (int i = 1; i <= max_cycles && !seen; i++) begin
      if (instr_done) begin
        n = i;
        seen = 1'b1;
      end
      next_cycle();
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  initial begin
    rst = 1'b1; rst_t = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    dbg_addr = 5'd0; slow_addr = 32'hFFFF_FFFF; slow_waits = 0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr_done", {31'b0, instr_done}, 32'd0);
    check("rst_trap", {30'b0, trap_cause, 1'b0} | {31'b0, trap}, 32'd0);
    check("rst_r0", dbg_data, 32'd0);
    check("rst_to_req", {31'b0, t_req}, 32'd0);

    // Main program
    load(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));        // addi r1,r0,5
    load(32'h04, enc_r(5'd1, 5'd1, 5'd2, 6'h20));         // add  r2,r1,r1
    load(32'h08, enc_j(6'h02, 26'h8));                    // j 0x20
    load(32'h10, enc_j(6'h03, 26'h10));                   // jal 0x40
    load(32'h14, 32'hFC00_0000);                          // illegal
    load(32'h20, enc_i(6'h2B, 5'd0, 5'd2, 16'd8));        // sw r2,8(r0)
    load(32'h24, enc_i(6'h23, 5'd0, 5'd3, 16'd8));        // lw r3,8(r0)
    load(32'h28, enc_r(5'd1, 5'd2, 5'd4, 6'h22));         // sub r4,r1,r2
    load(32'h2C, enc_r(5'd4, 5'd1, 5'd5, 6'h2A));         // slt r5,r4,r1
    load(32'h30, enc_r(5'd1, 5'd2, 5'd6, 6'h25));         // or  r6,r1,r2
    load(32'h34, enc_r(5'd6, 5'd1, 5'd7, 6'h24));         // and r7,r6,r1
    load(32'h38, enc_i(6'h0A, 5'd4, 5'd8, 16'hFFFF));     // slti r8,r4,-1
    load(32'h3C, enc_j(6'h02, 26'h14));                   // j 0x50
    load(32'h40, enc_r(5'd31, 5'd0, 5'd0, 6'h08));        // jr r31
    load(32'h50, enc_i(6'h04, 5'd1, 5'd1, 16'd2));        // beq r1,r1,+2 -> 0x5C
    load(32'h5C, enc_i(6'h04, 5'd1, 5'd2, 16'd3));        // beq r1,r2 (not taken)
    load(32'h60, enc_j(6'h02, 26'h4));                    // j 0x10
    slow_addr = 32'h8; slow_waits = 2;

    @(negedge clock);
    rst = 1'b0;
    #1;

    // Reset and first fetch
    check("fetch0_req", {31'b0, mem_req}, 32'd1);
    check("fetch0_addr", mem_addr, 32'h0);
    wait_done(10, cyc);
    check("addi_cycles", cyc, 32'd4);
    dbg_addr = 5'd2;
    wait_done(10, cyc);
    check("add_cycles", cyc, 32'd4);
    check("r2_after_add", dbg_data, 32'd10);

    // Slow fetch of j at 0x08
    wait_done(10, cyc);
    check("j_slow_cycles", cyc, 32'd4);
    check("pc_after_j20", pc, 32'h20);

    // sw with two wait states on the data access
    repeat (3) next_cycle();
    check("sw_req", {31'b0, mem_req}, 32'd1);
    check("sw_we", {31'b0, mem_we}, 32'd1);
    check("sw_addr", mem_addr, 32'h8);
    check("sw_wdata", mem_wdata, 32'd10);
    next_cycle();
    check("sw_addr_stable", mem_addr, 32'h8);
    wait_done(10, cyc);
    check("sw_tail_cycles", cyc, 32'd2);
    check("mem_word8", mem[2], 32'd10);

    dbg_addr = 5'd3;
    wait_done(12, cyc);
    check("lw_cycles", cyc, 32'd7);
    check("r3_lw", dbg_data, 32'd10);

    // ALU operations
    dbg_addr = 5'd4;
    wait_done(10, cyc);
    check("sub_cycles", cyc, 32'd4);
    check("r4_sub", dbg_data, 32'hFFFF_FFFB);
    dbg_addr = 5'd5;
    wait_done(10, cyc);
    check("r5_slt", dbg_data, 32'd1);
    dbg_addr = 5'd6;
    wait_done(10, cyc);
    check("r6_or", dbg_data, 32'd15);
    dbg_addr = 5'd7;
    wait_done(10, cyc);
    check("r7_and", dbg_data, 32'd5);
    dbg_addr = 5'd8;
    wait_done(10, cyc);
    check("slti_cycles", cyc, 32'd4);
    check("r8_slti", dbg_data, 32'd1);

    // Branches and jumps
    wait_done(10, cyc);
    check("pc_after_j50", pc, 32'h50);
    wait_done(10, cyc);
    check("beq_taken_cycles", cyc, 32'd3);
    check("beq_taken_pc", pc, 32'h5C);
    wait_done(10, cyc);
    check("beq_not_taken_pc", pc, 32'h60);
    wait_done(10, cyc);
    check("pc_after_j10", pc, 32'h10);
    dbg_addr = 5'd31;
    wait_done(10, cyc);
    check("jal_cycles", cyc, 32'd2);
    check("jal_pc", pc, 32'h40);
    check("jal_r31", dbg_data, 32'h14);
    wait_done(10, cyc);
    check("jr_cycles", cyc, 32'd2);
    check("jr_pc", pc, 32'h14);

    // Illegal instruction at 0x14
    next_cycle();
    check("illegal_no_done", {31'b0, instr_done}, 32'd0);
    next_cycle();
    check("illegal_trap", {31'b0, trap}, 32'd1);
    check("illegal_cause", {30'b0, trap_cause}, 32'd1);
    check("illegal_req", {31'b0, mem_req}, 32'd0);
    repeat (5) next_cycle();
    check("illegal_pc_frozen", pc, 32'h18);
    check("illegal_req_held", {31'b0, mem_req}, 32'd0);

    // Misaligned load: lw r1,2(r0)
    rst = 1'b1;
    slow_addr = 32'hFFFF_FFFF;
    load(32'h00, enc_i(6'h23, 5'd0, 5'd1, 16'd2));
    @(negedge clock);
    rst = 1'b0;
    #1;
    next_cycle();
    check("mis_decode_req", {31'b0, mem_req}, 32'd0);
    next_cycle();
    check("mis_exec_req", {31'b0, mem_req}, 32'd0);
    next_cycle();
    check("mis_trap", {31'b0, trap}, 32'd1);
    check("mis_cause", {30'b0, trap_cause}, 32'd2);
    check("mis_req", {31'b0, mem_req}, 32'd0);

    // Reset during a pending sw to 0x80
    rst = 1'b1;
    load(32'h00, enc_i(6'h2B, 5'd0, 5'd0, 16'h0080));    // sw r0,0x80(r0)
    load(32'h80, 32'h1234_5678);
    slow_addr = 32'h80; slow_waits = 5;
    @(negedge clock);
    rst = 1'b0;
    #1;
    repeat (3) next_cycle();
    check("mid_req", {31'b0, mem_req}, 32'd1);
    check("mid_addr", mem_addr, 32'h80);
    next_cycle();
    rst = 1'b1;
    #1;
    check("mid_req_drop", {31'b0, mem_req}, 32'd0);
    check("mid_pc", pc, 32'h0);
    repeat (3) next_cycle();
    check("mid_mem_unchanged", mem[32], 32'h1234_5678);

    // Bus timeout with MAX_WAIT=4
    @(negedge clock);
    rst_t = 1'b0;
    #1;
    check("to_req", {31'b0, t_req}, 32'd1);
    check("to_addr", t_addr, 32'h0);
    repeat (3) next_cycle();
    check("to_no_trap_yet", {31'b0, t_trap}, 32'd0);
    next_cycle();
    check("to_trap", {31'b0, t_trap}, 32'd1);
    check("to_cause", {30'b0, t_cause}, 32'd3);
    check("to_req_low", {31'b0, t_req}, 32'd0);
    check("to_quiet", {29'b0, t_we, t_done, 1'b0} | t_wdata | t_dbg | t_pc, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_mips_core.md
# mc_mips_core

Multi-cycle MIPS-subset core: the next-generation replacement for the single-cycle datapath and its controller. It executes the same instruction subset plus `jal`/`jr`. It uses one shared instruction/data memory port with a ready handshake and optional wait-state timeout, and runs a FETCH/DECODE/EXEC/MEM/WB state machine. It sits between the testbench/top level and a unified memory model, and contains its own register file.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- `ADDR_W`, 32, width of `mem_addr`; the byte address is truncated to its low `ADDR_W` bits.
- `MAX_WAIT`, 0, consecutive cycles `mem_req` may stay high without `mem_ready` before trap; 0 disables the timeout.
- `clock`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_req`  out  1  memory access request; held until the cycle `mem_ready`=1.
- `mem_we`  out  1  1 = write (only during `sw` MEM).
- `mem_addr`  out  ADDR_W  byte address, always word aligned.
- `mem_wdata`  out  32  store data (register rt).
- `mem_rdata`  in  32  read data; sampled in the cycle `mem_ready`=1.
- `mem_ready`  in  1  access completes this cycle; may be high in the same cycle `mem_req` rises.
- `pc`  out  32  current PC.
- `instr_done`  out  1  one-cycle pulse in the last cycle of each retired instruction.
- `trap`  out  1  sticky error flag.
- `trap_cause`  out  2  0 none, 1 illegal opcode/funct, 2 misaligned address, 3 bus timeout.
- `dbg_addr`  in  5  register-file debug read index.
- `dbg_data`  out  32  combinational read of `regs[dbg_addr]`; reads 0 for r0.

## Operation
- Supported instructions:
  - R-type (op 0) by funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08.
  - I/J-type by opcode: addi 0x08, slti 0x0A, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
- Arithmetic rules:
  - add/sub/addi wrap modulo 2^32; there is no overflow trap.
  - slt/slti compare signed and write 0 or 1.
  - Immediates are sign-extended.
- Registers:
  - r0 reads 0, and writes to it are discarded.
  - All 32 registers clear on reset.
- Internal registers: IR, A, B, ALUOut, MDR, PC.
- FETCH:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=PC.
  - On `mem_ready`: IR←`mem_rdata`, PC←PC+4, go to DECODE.
- DECODE:
  - A←rs, B←rt; ALUOut←PC+(sext(imm)<<2) as the branch target.
  - j: PC←{PC[31:28],idx,2'b00}, then FETCH.
  - jal: same PC update, plus r31←PC (the already-incremented value), then FETCH.
  - jr: if rs[1:0]≠0 → ERR; otherwise PC←rs, then FETCH.
  - Illegal opcode/funct → ERR (cause 1).
  - All other instructions → EXEC.
- EXEC:
  - beq: if A==B then PC←ALUOut; then FETCH.
  - R-type/addi/slti: ALUOut←result, then WB.
  - lw/sw: ALUOut←A+sext(imm). If the sum's [1:0]≠0 → ERR (cause 2); otherwise MEM.
- MEM:
  - Drive `mem_req`=1, `mem_addr`=ALUOut, `mem_we`=1 for sw.
  - On `mem_ready`: lw captures MDR and goes to WB; sw goes to FETCH.
- WB:
  - rd←ALUOut for R-type; rt←ALUOut for addi/slti; rt←MDR for lw.
  - Then FETCH.
- ERR:
  - Absorbing state: `trap`=1, `mem_req`=0, PC frozen.
  - Only `rst` exits it.
- Timeout: if MAX_WAIT>0 and `mem_req` has been high for MAX_WAIT consecutive cycles without `mem_ready` → ERR (cause 3). The wait counter clears on every `mem_ready` and on every state change.
- `instr_done` pulses in the cycle the FSM leaves DECODE/EXEC/MEM/WB for FETCH. It does not pulse on entry to ERR.

## Timing
- Reset values (asynchronous):
  - state=FETCH, PC=RESET_PC.
  - IR/A/B/ALUOut/MDR=0, all registers 0.
  - `mem_req`=0 while `rst` is high, `mem_we`=0.
  - `instr_done`=0, `trap`=0, `trap_cause`=0.
- First `mem_req` is asserted in the first cycle after `rst` deasserts.
- Cycles per instruction with zero wait states: j/jal/jr 2; beq 3; R-type/addi/slti/sw 4; lw 5. Each memory wait cycle adds 1.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable while waiting for `mem_ready`.
- `mem_ready` while `mem_req`=0 is ignored.
- Reset mid-access: the request drops immediately and no register write occurs.
- Register-file writes commit at the rising edge ending WB (or ending DECODE for jal). `dbg_data` reflects a write the cycle after that edge.

## Structure
- Shared package `mips_pkg`:
  - opcode and funct localparams;
  - state enum {FETCH, DECODE, EXEC, MEM, WB, ERR};
  - trap_cause codes;
  - ALU operation codes.
- One sub-module: `mips_regfile` (32×32, two combinational read ports plus the debug port, one synchronous write port, asynchronous clear).
- ALU, FSM and datapath registers stay in `mc_mips_core`.

## Test plan
- **Reset and first fetch.** Reset, then zero-wait memory holding `addi r1,r0,5`; `add r2,r1,r1` → `mem_addr`=0 first; r2=10 via `dbg_data`; `instr_done` pulses at cycles 4 and 8.
- **Load/store round trip.** `sw r2,8(r0)`; `lw r3,8(r0)` with 2 wait states per access → memory word 8=10; r3=10; lw takes 7 cycles.
- **Branch and jumps.**
  - `beq` taken → PC=target.
  - `beq` not taken → PC=PC+4.
  - `jal 0x40` from PC 0x10 → r31=0x14, PC=0x40.
  - `jr r31` → PC=0x14.
- **Illegal instruction.** Fetch 0xFC000000 → `trap`=1, `trap_cause`=1, `mem_req` stays 0 and PC is frozen until reset.
- **Misaligned access and timeout.**
  - `lw r1,2(r0)` → `trap_cause`=2 with no MEM request issued.
  - MAX_WAIT=4 with `mem_ready` tied low → `trap_cause`=3 after 4 request cycles.
- **Reset mid-access.** Assert `rst` during a pending sw → `mem_req` drops in the same cycle; memory is unchanged; PC=RESET_PC.
